fan_drive_sequencer: RTL and testbench
======================================

# fan_drive_sequencer

Fan speed controller that sits between the user inputs (debounced button pulse, sleep-timer expiry, ultrasonic obstacle flag) and the 100%-scale PWM generator. It keeps the selected speed level and arbitrates the stop/pause sources by fixed priority. It ramps the PWM duty one step per ramp tick toward the level's target, so the motor soft-starts and soft-stops. It also drives the level LEDs and the idle flag for the rest of the fan design.

## Interface
- RAMP_DIV, 1_000_000: clk cycles per ramp tick (≥2).
- RESUME_TICKS, 100: consecutive obstacle-free ticks needed to resume from pause (≥1).
- DUTY_LOW, 10: target duty for level 1.
- DUTY_MID, 20: target duty for level 2.
- DUTY_HIGH, 30: target duty for level 3 (≤127).
- clk  input  1  system clock.
- reset_p  input  1  reset; one clock; reset is asynchronous and active-high.
- btn_pe  input  1  one-cycle pulse, debounced speed button.
- timer_end  input  1  level; sleep timer expired.
- obstacle  input  1  level; ultrasonic reports object too close.
- duty  output  7  duty command to PWM, 0..127.
- level  output  2  current speed level, 0 = off.
- led_power  output  3  one-hot level LEDs.
- motor_idle  output  1  high after a user or timer stop; low once running.
- ramp_busy  output  1  high while duty ≠ target.

## Operation
- States: OFF, ACTIVE, PAUSED.
- Source priority per cycle: reset_p > timer_end > obstacle > btn_pe. A lower-priority event in the same cycle is dropped, not queued.
- timer_end high, any state:
  - Next state OFF, level 0, motor_idle 1.
  - Held high, it keeps the block in OFF and button pulses are ignored.
- OFF:
  - btn_pe: go to ACTIVE, level 1, motor_idle 0.
  - obstacle: ignored.
- ACTIVE:
  - obstacle high: go to PAUSED; level is retained; the resume counter is cleared.
  - Otherwise btn_pe steps the level 1→2, 2→3, 3→0.
  - On 3→0: go to OFF, motor_idle 1.
- PAUSED:
  - btn_pe is ignored.
  - The resume counter is cleared on any cycle with obstacle high.
  - On each tick with obstacle low, the counter increments.
  - When the count reaches RESUME_TICKS, go to ACTIVE at the retained level and clear the counter.
- Target duty:
  - ACTIVE: the level's value (1→DUTY_LOW, 2→DUTY_MID, 3→DUTY_HIGH).
  - OFF and PAUSED: 0.
  - Target is computed combinationally from the current (pre-update) state and level.
- Ramp, on ticks only:
  - If duty < target, duty increments by 1.
  - If duty > target, duty decrements by 1.
  - If equal, duty holds.
  - Duty never wraps, never exceeds DUTY_HIGH, and never goes below 0.
- led_power:
  - Level 1 → 001, level 2 → 010, level 3 → 100.
  - 000 when level is 0.
  - Shown in both ACTIVE and PAUSED.
- ramp_busy = (duty ≠ target), combinational.

## Timing
- Reset values: state OFF, level 0, duty 0, led_power 000, motor_idle 0, ramp_busy 0, prescaler 0, resume counter 0.
- Prescaler:
  - Free-runs 0..RAMP_DIV-1 from reset.
  - tick is an internal one-cycle pulse when the count equals RAMP_DIV-1.
  - The prescaler is not resynchronised by events.
- Event latency: state, level, led_power and motor_idle are registered and update on the clock edge where btn_pe, timer_end or obstacle is sampled.
- Ramp latency:
  - Duty moves on the first tick after the target changes.
  - 0→DUTY_LOW takes DUTY_LOW ticks.
  - DUTY_HIGH→0 takes DUTY_HIGH ticks.
- Button and tick in the same cycle: the level updates, and the ramp step uses the old target.
- A target change mid-ramp reverses or redirects the ramp from the current duty; there is no restart from 0.
- Reset asserted mid-ramp: all registers return to reset values immediately (asynchronous); duty is 0 in the same cycle.

## Test plan
Sim parameters: RAMP_DIV=4, RESUME_TICKS=3.

- Reset, then one btn_pe:
  - Next cycle: level=1, led_power=001, motor_idle=0, ramp_busy=1.
  - duty reaches 10 after 10 ticks (~40 cycles), then ramp_busy=0.
- Four btn_pe pulses spaced 200 cycles apart:
  - duty settles 10→20→30→0; led_power 001→010→100→000.
  - motor_idle=1 after the fourth pulse; duty decrements 30→0 over 30 ticks.
- Level 3 settled, obstacle high for 50 cycles:
  - State PAUSED, led_power stays 100, duty ramps down.
  - After obstacle falls, resume occurs after 3 clean ticks; duty ramps back to 30.
  - A btn_pe during the pause has no effect.
- Obstacle toggling high every 2nd tick during PAUSED: the block never resumes.
- timer_end and btn_pe in the same cycle at level 2:
  - Result: OFF, level 0, motor_idle=1, led_power 000.
  - duty ramps 20→0, and a btn_pe while timer_end is held is ignored.
- Reset asserted while duty=15 and ramping: duty=0, level=0 and led_power=000 asynchronously; no tick-dependent output change afterwards until btn_pe.

Source files
------------

// File: rtl/fan_drive_sequencer.sv
// Fan speed sequencer: speed level FSM with timer/obstacle/button arbitration
// and a tick-paced duty ramp toward the level's target for the PWM generator.
module fan_drive_sequencer #(
  parameter int RAMP_DIV     = 1_000_000,
  parameter int RESUME_TICKS = 100,
  parameter int DUTY_LOW     = 10,
  parameter int DUTY_MID     = 20,
  parameter int DUTY_HIGH    = 30
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       btn_pe,
  input  logic       timer_end,
  input  logic       obstacle,
  output logic [6:0] duty,
  output logic [1:0] level,
  output logic [2:0] led_power,
  output logic       motor_idle,
  output logic       ramp_busy
);

  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int RW = $clog2(RESUME_TICKS + 1);
  localparam logic [PW-1:0] PRESC_MAX  = PW'(RAMP_DIV - 1);
  localparam logic [RW-1:0] RESUME_MAX = RW'(RESUME_TICKS - 1);

  typedef enum logic [1:0] {S_OFF, S_ACTIVE, S_PAUSED} state_t;

  state_t        state_q, state_d;
  logic [1:0]    level_q, level_d;
  logic [6:0]    duty_q, duty_d;
  logic [2:0]    led_q, led_d;
  logic          idle_q, idle_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [RW-1:0] resume_q, resume_d;
  logic [6:0]    target;
  logic          tick;

  assign tick = (presc_q == PRESC_MAX);

  // Target follows the pre-update state, so a same-cycle button uses the old target.
  always_comb begin
    target = '0;
    if (state_q == S_ACTIVE) begin
      case (level_q)
        2'd1:    target = 7'(DUTY_LOW);
        2'd2:    target = 7'(DUTY_MID);
        2'd3:    target = 7'(DUTY_HIGH);
        default: target = '0;
      endcase
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    level_d  = level_q;
    idle_d   = idle_q;
    resume_d = resume_q;
    duty_d   = duty_q;
    presc_d  = tick ? '0 : presc_q + PW'(1);

    if (tick) begin
      if (duty_q < target)      duty_d = duty_q + 7'd1;
      else if (duty_q > target) duty_d = duty_q - 7'd1;
    end

    if (timer_end) begin
      state_d  = S_OFF;
      level_d  = 2'd0;
      idle_d   = 1'b1;
      resume_d = '0;
    end else begin
      case (state_q)
        S_OFF: begin
          if (btn_pe) begin
            state_d = S_ACTIVE;
            level_d = 2'd1;
            idle_d  = 1'b0;
          end
        end
        S_ACTIVE: begin
          if (obstacle) begin
            state_d  = S_PAUSED;
            resume_d = '0;
          end else if (btn_pe) begin
            if (level_q == 2'd3) begin
              state_d = S_OFF;
              level_d = 2'd0;
              idle_d  = 1'b1;
            end else begin
              level_d = level_q + 2'd1;
            end
          end
        end
        S_PAUSED: begin
          if (obstacle) begin
            resume_d = '0;
          end else if (tick) begin
            if (resume_q == RESUME_MAX) begin
              state_d  = S_ACTIVE;
              resume_d = '0;
            end else begin
              resume_d = resume_q + RW'(1);
            end
          end
        end
        default: state_d = S_OFF;
      endcase
    end

    case (level_d)
      2'd1:    led_d = 3'b001;
      2'd2:    led_d = 3'b010;
      2'd3:    led_d = 3'b100;
      default: led_d = 3'b000;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q  <= S_OFF;
      level_q  <= 2'd0;
      duty_q   <= '0;
      led_q    <= 3'b000;
      idle_q   <= 1'b0;
      presc_q  <= '0;
      resume_q <= '0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      duty_q   <= duty_d;
      led_q    <= led_d;
      idle_q   <= idle_d;
      presc_q  <= presc_d;
      resume_q <= resume_d;
    end
  end

  assign duty       = duty_q;
  assign level      = level_q;
  assign led_power  = led_q;
  assign motor_idle = idle_q;
  assign ramp_busy  = (duty_q != target);

endmodule

// File: tb/tb_fan_drive_sequencer.sv
// Scoreboard bench for fan_drive_sequencer: directed scenarios plus random
// stimulus, checked against a cycle-level behavioural model of the fan rules.
module tb_fan_drive_sequencer;

  localparam int RD = 4;
  localparam int RT = 3;
  localparam int DL = 10;
  localparam int DM = 20;
  localparam int DH = 30;

  logic       clk = 1'b0;
  logic       reset_p = 1'b0;
  logic       btn_pe = 1'b0;
  logic       timer_end = 1'b0;
  logic       obstacle = 1'b0;
  logic [6:0] duty;
  logic [1:0] level;
  logic [2:0] led_power;
  logic       motor_idle;
  logic       ramp_busy;

  fan_drive_sequencer #(
    .RAMP_DIV(RD), .RESUME_TICKS(RT),
    .DUTY_LOW(DL), .DUTY_MID(DM), .DUTY_HIGH(DH)
  ) dut (
    .clk(clk), .reset_p(reset_p), .btn_pe(btn_pe), .timer_end(timer_end),
    .obstacle(obstacle), .duty(duty), .level(level), .led_power(led_power),
    .motor_idle(motor_idle), .ramp_busy(ramp_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] duty;
    logic [1:0] level;
    logic [2:0] led;
    logic       idle;
    logic       busy;
  } exp_t;

  typedef enum {M_OFF, M_RUN, M_PAUSE} mstate_t;

  exp_t    exp_q[$];
  int      checks = 0;
  int      failures = 0;

  mstate_t m_st;
  int      m_lvl, m_duty, m_rc, m_cyc;
  bit      m_idle;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  function automatic int target_of(input mstate_t st, input int lvl);
    if (st != M_RUN) return 0;
    return (lvl == 1) ? DL : (lvl == 2) ? DM : (lvl == 3) ? DH : 0;
  endfunction

  function automatic exp_t snapshot();
    exp_t e;
    e.duty  = 7'(m_duty);
    e.level = 2'(m_lvl);
    e.led   = (m_lvl == 0) ? 3'b000 : 3'(1 << (m_lvl - 1));
    e.idle  = m_idle;
    e.busy  = (m_duty != target_of(m_st, m_lvl));
    return e;
  endfunction

  // Advance the fan model by one clock edge with the given input levels.
  task automatic model_step(input bit b, input bit t, input bit o);
    bit tk;
    int tgt;
    tk  = ((m_cyc % RD) == RD - 1);
    m_cyc++;
    tgt = target_of(m_st, m_lvl);
    if (tk && m_duty < tgt) m_duty++;
    else if (tk && m_duty > tgt) m_duty--;
    if (t) begin
      m_st = M_OFF; m_lvl = 0; m_idle = 1; m_rc = 0;
    end else if (m_st == M_OFF) begin
      if (b) begin m_st = M_RUN; m_lvl = 1; m_idle = 0; end
    end else if (m_st == M_RUN) begin
      if (o) begin
        m_st = M_PAUSE; m_rc = 0;
      end else if (b) begin
        if (m_lvl == 3) begin m_st = M_OFF; m_lvl = 0; m_idle = 1; end
        else m_lvl++;
      end
    end else begin
      if (o) m_rc = 0;
      else if (tk) begin
        m_rc++;
        if (m_rc == RT) begin m_st = M_RUN; m_rc = 0; end
      end
    end
    exp_q.push_back(snapshot());
  endtask

  task automatic cycle(input bit b, input bit t, input bit o);
    btn_pe = b; timer_end = t; obstacle = o;
    model_step(b, t, o);
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n, input bit t, input bit o);
    repeat (n) cycle(1'b0, t, o);
  endtask

  task automatic do_reset();
    m_st = M_OFF; m_lvl = 0; m_duty = 0; m_rc = 0; m_cyc = 0; m_idle = 0;
    btn_pe = 1'b0; timer_end = 1'b0; obstacle = 1'b0;
    exp_q.push_back(snapshot());
    reset_p = 1'b1;
    #2;
    reset_p = 1'b0;
  endtask

  initial begin : monitor
    forever begin
      exp_t e;
      @(posedge clk or posedge reset_p);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("duty",       32'(duty),       32'(e.duty));
        check("level",      32'(level),      32'(e.level));
        check("led_power",  32'(led_power),  32'(e.led));
        check("motor_idle", 32'(motor_idle), 32'(e.idle));
        check("ramp_busy",  32'(ramp_busy),  32'(e.busy));
      end
    end
  end

  initial begin : stimulus
    bit obs_v, btn_v, tmr_v;
    int obs_run, n;
    @(negedge clk);
    do_reset();

    // Power-on, then step through all levels with settle time.
    cycle(1'b1, 1'b0, 1'b0);
    idle_cycles(199, 1'b0, 1'b0);
    repeat (3) begin
      cycle(1'b1, 1'b0, 1'b0);
      idle_cycles(199, 1'b0, 1'b0);
    end

    // Level 3 settled, obstacle pause with an ignored button, then resume.
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    idle_cycles(200, 1'b0, 1'b0);
    idle_cycles(25, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    idle_cycles(24, 1'b0, 1'b1);
    idle_cycles(200, 1'b0, 1'b0);

    // Obstacle pulsing every second tick keeps the block paused.
    idle_cycles(5, 1'b0, 1'b1);
    repeat (15) begin
      cycle(1'b0, 1'b0, 1'b1);
      idle_cycles(7, 1'b0, 1'b0);
    end
    idle_cycles(150, 1'b0, 1'b0);

    // Timer and button together at level 2, button ignored while timer held.
    cycle(1'b1, 1'b0, 1'b0);
    repeat (2) cycle(1'b1, 1'b0, 1'b0);
    idle_cycles(100, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    idle_cycles(10, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    idle_cycles(10, 1'b1, 1'b0);
    idle_cycles(150, 1'b0, 1'b0);

    // Asynchronous reset while ramping through duty 15.
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    n = 0;
    while (m_duty != 15 && n < 500) begin
      cycle(1'b0, 1'b0, 1'b0);
      n++;
    end
    if (n >= 500) begin
      checks++; failures++;
      $display("FAIL wait_duty15: model duty %0d never reached 15", m_duty);
    end
    do_reset();
    idle_cycles(40, 1'b0, 1'b0);

    // Randomized mix of buttons, timer pulses and obstacle runs.
    obs_v = 1'b0; obs_run = 0;
    for (int i = 0; i < 3000; i++) begin
      if (obs_run == 0) begin
        obs_v   = ~obs_v;
        obs_run = obs_v ? int'($urandom_range(1, 40)) : int'($urandom_range(5, 150));
      end
      obs_run--;
      tmr_v = ($urandom_range(0, 399) == 0);
      btn_v = ($urandom_range(0, 29) == 0);
      if (m_st == M_OFF && obs_v) btn_v = 1'b0;
      cycle(btn_v, tmr_v, obs_v);
    end
    idle_cycles(5, 1'b0, 1'b0);

    #3;
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain: %0d expectations never compared", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
